// File: rtl/ah_encoder_12_24.sv
// ---------------------------------------------------------------------------
// ah_encoder_12_24
//
// Transmit-side address encoder. Arbitrates the pending client requests
// round-robin. It latches the winner's local offset and forms the absolute
// egress address BASE_ADDR + (index << OFF_W) + offset. The address is
// offered on a valid/ready interface. An encoding that does not fit in
// ADDR_W bits is dropped: the requester is acknowledged and enc_err pulses.
//
// Optional feature (macro AH_ENC_ERR_COUNT_EN):
//   Adds the output err_count, a saturating 8-bit count of ERR-state cycles.
//   When the macro is undefined, the port and the counter do not exist.
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   reset            in   synchronous, active-high reset
//   client_req       in   per-client request, held until client_ack
//   client_offset    in   flattened offsets, client i at [i*OFF_W +: OFF_W]
//   client_ack       out  one-hot, one-cycle completion/drop acknowledge
//   egress_pkt_field out  encoded address
//   egress_valid     out  egress_pkt_field valid
//   egress_ready     in   downstream accepts
//   egress_grant     out  one-hot owner of the current transaction
//   enc_err          out  one-cycle pulse, address overflow, request dropped
//   err_count        out  saturating ERR-cycle count (AH_ENC_ERR_COUNT_EN only)
// ---------------------------------------------------------------------------
module ah_encoder_12_24 #(
    parameter int                N_CLIENTS = 12,
    parameter int                ADDR_W    = 24,
    parameter int                OFF_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CLIENTS-1:0]       client_req,
    input  logic [N_CLIENTS*OFF_W-1:0] client_offset,
    output logic [N_CLIENTS-1:0]       client_ack,
    output logic [ADDR_W-1:0]          egress_pkt_field,
    output logic                       egress_valid,
    input  logic                       egress_ready,
    output logic [N_CLIENTS-1:0]       egress_grant,
    output logic                       enc_err
`ifdef AH_ENC_ERR_COUNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;   // index of the most recently granted client

    logic             found;
    logic [IDX_W-1:0] win;
    logic [OFF_W-1:0] win_off;
    logic [ADDR_W:0]  sum;      // one extra bit catches overflow

    // Round-robin search starting just after rr_ptr. The candidate index
    // wraps explicitly because N_CLIENTS need not be a power of two.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        found = 1'b0;
        win   = rr_ptr;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            int               cand_i;
            logic [IDX_W-1:0] cand;
            cand_i = int'(rr_ptr) + k;
            if (cand_i >= N_CLIENTS) begin
                cand_i = cand_i - N_CLIENTS;
            end
            cand = cand_i[IDX_W-1:0];
            if (!found && client_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_off = client_offset[win*OFF_W +: OFF_W];
    assign sum     = (ADDR_W+1)'(BASE_ADDR)
                   + ((ADDR_W+1)'(win) << OFF_W)
                   + (ADDR_W+1)'(win_off);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            rr_ptr           <= IDX_W'(N_CLIENTS - 1);
            egress_pkt_field <= '0;
            egress_grant     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        rr_ptr       <= win;
                        egress_grant <= N_CLIENTS'(1) << win;
                        if (!sum[ADDR_W]) begin
                            egress_pkt_field <= sum[ADDR_W-1:0];
                            state            <= ST_SEND;
                        end else begin
                            // The field keeps its previous value when the request is dropped.
                            state <= ST_ERR;
                        end
                    end
                end
                ST_SEND: begin
                    if (egress_ready) begin
                        state        <= ST_IDLE;
                        egress_grant <= '0;
                    end
                end
                ST_ERR: begin
                    state        <= ST_IDLE;
                    egress_grant <= '0;
                end
                default: begin
                    state        <= ST_IDLE;
                    egress_grant <= '0;
                end
            endcase
        end
    end

    // During a reset cycle the transaction is abandoned. Neither ack nor err
    // is reported, even though state has not yet cleared.
    assign egress_valid = (state == ST_SEND);
    assign enc_err      = (state == ST_ERR) && !reset;
    assign client_ack   = (((state == ST_SEND) && egress_ready) || (state == ST_ERR)) && !reset
                        ? egress_grant : '0;

`ifdef AH_ENC_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'h00;
        end else if ((state == ST_ERR) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_ah_encoder_12_24.sv
// ---------------------------------------------------------------------------
// tb_ah_encoder_12_24
//
// Self-checking bench for ah_encoder_12_24. There are two instances: dut 0
// uses BASE_ADDR 0 and dut 1 uses BASE_ADDR 24'hFF8000, which exercises
// overflow. A transaction-level reference model predicts the owner, address,
// ack and err for each cycle. Directed scenarios add explicit checks for the
// documented corner cases.
// ---------------------------------------------------------------------------
module tb_ah_encoder_12_24;

    localparam int          N     = 12;
    localparam int          OW    = 12;
    localparam int          AW    = 24;
    localparam logic [23:0] BASE0 = 24'h000000;
    localparam logic [23:0] BASE1 = 24'hFF8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst  [2];
    logic [N-1:0]    req  [2];
    logic [N*OW-1:0] offs [2];
    logic            rdy  [2];
    logic [N-1:0]    ack  [2];
    logic [AW-1:0]   fld  [2];
    logic            vld  [2];
    logic [N-1:0]    gnt  [2];
    logic            err  [2];
`ifdef AH_ENC_ERR_COUNT_EN
    logic [7:0]      ecnt [2];
`endif

    ah_encoder_12_24 #(.BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .reset(rst[0]), .client_req(req[0]), .client_offset(offs[0]),
        .client_ack(ack[0]), .egress_pkt_field(fld[0]), .egress_valid(vld[0]),
        .egress_ready(rdy[0]), .egress_grant(gnt[0]), .enc_err(err[0])
`ifdef AH_ENC_ERR_COUNT_EN
        , .err_count(ecnt[0])
`endif
    );

    ah_encoder_12_24 #(.BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .reset(rst[1]), .client_req(req[1]), .client_offset(offs[1]),
        .client_ack(ack[1]), .egress_pkt_field(fld[1]), .egress_valid(vld[1]),
        .egress_ready(rdy[1]), .egress_grant(gnt[1]), .enc_err(err[1])
`ifdef AH_ENC_ERR_COUNT_EN
        , .err_count(ecnt[1])
`endif
    );

    int passed;
    int total;

    // Reference model: busy phase (0 idle, 1 sending, 2 dropped), owner,
    // last winner, last published address, error count.
    int          m_phase [2];
    int          m_owner [2];
    int          m_last  [2];
    logic [23:0] m_field [2];
    int          m_cnt   [2];

    function automatic logic [23:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    // First requesting client after 'last', in circular order.
    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One clock of dut d. The caller sets the inputs first. This task checks
    // the combinational ack, retires the acked request, advances the model
    // and then checks the registered outputs after the edge.
    task automatic step(input int d);
        logic [N-1:0]    exp_ack;
        logic [N-1:0]    exp_gnt;
        logic [N-1:0]    req_e;
        logic [N*OW-1:0] off_e;
        logic            exp_v;
        logic            exp_e;
        longint          sum;
        int              w;
        #1;
        exp_ack = '0;
        if (!rst[d] && (m_phase[d] == 2 || (m_phase[d] == 1 && rdy[d])))
            exp_ack = N'(1) << m_owner[d];
        total++;
        if (ack[d] !== exp_ack) $display("FAIL ack dut%0d: got %h expected %h", d, ack[d], exp_ack);
        else passed++;
        req[d] = req[d] & ~exp_ack;
        req_e  = req[d];
        off_e  = offs[d];
        if (rst[d]) begin
            m_phase[d] = 0; m_last[d] = N - 1; m_field[d] = '0; m_cnt[d] = 0;
        end else begin
            if (m_phase[d] == 2 && m_cnt[d] < 255) m_cnt[d]++;
            if (exp_ack != '0) begin
                m_phase[d] = 0;
            end else if (m_phase[d] == 0 && req_e != '0) begin
                w = rr_pick(m_last[d], req_e);
                m_last[d]  = w;
                m_owner[d] = w;
                sum = longint'(base_of(d)) + longint'(w) * 4096 + longint'(off_e[w*OW +: OW]);
                if (sum < 64'h100_0000) begin
                    m_field[d] = sum[23:0];
                    m_phase[d] = 1;
                end else begin
                    m_phase[d] = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        exp_v   = (m_phase[d] == 1);
        exp_e   = (m_phase[d] == 2) && !rst[d];
        exp_gnt = (m_phase[d] != 0) ? (N'(1) << m_owner[d]) : '0;
        total++;
        if (vld[d] !== exp_v) $display("FAIL valid dut%0d: got %b expected %b", d, vld[d], exp_v);
        else passed++;
        total++;
        if (err[d] !== exp_e) $display("FAIL enc_err dut%0d: got %b expected %b", d, err[d], exp_e);
        else passed++;
        total++;
        if (gnt[d] !== exp_gnt) $display("FAIL grant dut%0d: got %h expected %h", d, gnt[d], exp_gnt);
        else passed++;
        total++;
        if (fld[d] !== m_field[d]) $display("FAIL field dut%0d: got %h expected %h", d, fld[d], m_field[d]);
        else passed++;
`ifdef AH_ENC_ERR_COUNT_EN
        total++;
        if (ecnt[d] !== 8'(m_cnt[d])) $display("FAIL err_count dut%0d: got %0d expected %0d", d, ecnt[d], m_cnt[d]);
        else passed++;
`endif
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1; req[d] = '0; rdy[d] = 1'b0;
        step(d);
        rst[d] = 1'b0;
    endtask

    task automatic set_off(input int d, input int c, input logic [11:0] v);
        offs[d][c*OW +: OW] = v;
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1; req[d] = '1; rdy[d] = 1'b1;
        step(d);
        step(d);
        #1;
        total++;
        if (ack[d] !== '0) $display("FAIL reset_ack dut%0d: got %h expected 0", d, ack[d]);
        else passed++;
        total++;
        if ({vld[d], err[d], gnt[d], fld[d]} !== '0)
            $display("FAIL reset_outputs dut%0d: got v=%b e=%b g=%h f=%h expected all 0", d, vld[d], err[d], gnt[d], fld[d]);
        else passed++;
        rst[d] = 1'b0; req[d] = '0; rdy[d] = 1'b0;
        step(d);
    endtask

    task automatic test_single_hold;
        do_reset(0);
        set_off(0, 0, 12'h123);
        req[0] = 12'h001; rdy[0] = 1'b0;
        step(0);
        total++;
        if (vld[0] !== 1'b1 || fld[0] !== 24'h000123 || gnt[0] !== 12'h001)
            $display("FAIL single_first got v=%b f=%h g=%h expected 1 000123 001", vld[0], fld[0], gnt[0]);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step(0);
            total++;
            if (vld[0] !== 1'b1 || fld[0] !== 24'h000123)
                $display("FAIL single_hold cycle %0d got v=%b f=%h expected 1 000123", i, vld[0], fld[0]);
            else passed++;
        end
        rdy[0] = 1'b1;
        #1;
        total++;
        if (ack[0] !== 12'h001) $display("FAIL single_ack got %h expected 001", ack[0]);
        else passed++;
        step(0);
        total++;
        if (vld[0] !== 1'b0 || gnt[0] !== 12'h000 || fld[0] !== 24'h000123)
            $display("FAIL single_done got v=%b g=%h f=%h expected 0 000 000123", vld[0], gnt[0], fld[0]);
        else passed++;
        rdy[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset(0);
        for (int c = 0; c < N; c++) set_off(0, c, 12'($urandom));
        set_off(0, 11, 12'hFFF);
        rdy[0] = 1'b1;
        for (int i = 0; i <= N; i++) begin
            req[0] = '1;
            step(0);
            total++;
            if (gnt[0] !== (N'(1) << (i % N)))
                $display("FAIL b2b_grant txn %0d got %h expected %h", i, gnt[0], N'(1) << (i % N));
            else passed++;
            if (i == 11) begin
                total++;
                if (fld[0] !== 24'h00BFFF) $display("FAIL b2b_client11 got %h expected 00bfff", fld[0]);
                else passed++;
            end
            step(0);
        end
        req[0] = '0; rdy[0] = 1'b0;
        step(0);
    endtask

    task automatic test_fairness;
        do_reset(0);
        rdy[0] = 1'b1;
        req[0] = 12'h008;
        step(0);
        total++;
        if (gnt[0] !== 12'h008) $display("FAIL fair_first got %h expected 008", gnt[0]);
        else passed++;
        step(0);
        req[0] = 12'h009;
        step(0);
        total++;
        if (gnt[0] !== 12'h001) $display("FAIL fair_wrap got %h expected 001", gnt[0]);
        else passed++;
        step(0);
        step(0);
        total++;
        if (gnt[0] !== 12'h008) $display("FAIL fair_next got %h expected 008", gnt[0]);
        else passed++;
        step(0);
        req[0] = '0; rdy[0] = 1'b0;
    endtask

    task automatic test_overflow;
        do_reset(1);
        set_off(1, 7, 12'hFFF);
        set_off(1, 8, 12'h000);
        req[1] = 12'h080; rdy[1] = 1'b1;
        step(1);
        total++;
        if (vld[1] !== 1'b1 || fld[1] !== 24'hFFFFFF)
            $display("FAIL ovf_top got v=%b f=%h expected 1 ffffff", vld[1], fld[1]);
        else passed++;
        step(1);
        req[1] = 12'h100; rdy[1] = 1'b0;
        step(1);
        total++;
        if (err[1] !== 1'b1 || vld[1] !== 1'b0)
            $display("FAIL ovf_err got e=%b v=%b expected 1 0", err[1], vld[1]);
        else passed++;
        #1;
        total++;
        if (ack[1] !== 12'h100) $display("FAIL ovf_ack got %h expected 100", ack[1]);
        else passed++;
        step(1);
        total++;
        if (err[1] !== 1'b0 || vld[1] !== 1'b0)
            $display("FAIL ovf_after got e=%b v=%b expected 0 0", err[1], vld[1]);
        else passed++;
`ifdef AH_ENC_ERR_COUNT_EN
        total++;
        if (ecnt[1] !== 8'd1) $display("FAIL ovf_count got %0d expected 1", ecnt[1]);
        else passed++;
`endif
    endtask

    task automatic test_reset_in_send;
        do_reset(0);
        set_off(0, 5, 12'($urandom));
        set_off(0, 7, 12'($urandom));
        req[0] = 12'h020; rdy[0] = 1'b0;
        step(0);
        total++;
        if (gnt[0] !== 12'h020) $display("FAIL rsend_grant got %h expected 020", gnt[0]);
        else passed++;
        // Client 7 also requests. Without a pointer reset it would win next.
        req[0] = 12'h0A0; rst[0] = 1'b1;
        step(0);
        total++;
        if ({vld[0], err[0], gnt[0], fld[0]} !== '0)
            $display("FAIL rsend_cleared got v=%b e=%b g=%h f=%h expected all 0", vld[0], err[0], gnt[0], fld[0]);
        else passed++;
        rst[0] = 1'b0;
        step(0);
        total++;
        if (gnt[0] !== 12'h020) $display("FAIL rsend_regrant got %h expected 020", gnt[0]);
        else passed++;
        rdy[0] = 1'b1;
        step(0);
        req[0] = '0; rdy[0] = 1'b0;
        step(0);
    endtask

    task automatic test_random(input int d);
        do_reset(d);
        for (int i = 0; i < 600; i++) begin
            rdy[d] = ($urandom_range(0, 2) != 0);
            rst[d] = ($urandom_range(0, 79) == 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0) set_off(d, c, 12'($urandom));
                if (!req[d][c] && $urandom_range(0, 3) == 0) req[d][c] = 1'b1;
            end
            step(d);
        end
        rst[d] = 1'b0; req[d] = '0; rdy[d] = 1'b0;
        step(d);
        step(d);
    endtask

`ifdef AH_ENC_ERR_COUNT_EN
    task automatic test_err_saturate;
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            int c;
            c = 8 + int'($urandom_range(0, 3));
            set_off(1, c, 12'($urandom));
            req[1] = N'(1) << c;
            rdy[1] = $urandom_range(0, 1) != 0;
            step(1);
            step(1);
        end
        total++;
        if (ecnt[1] !== 8'hFF) $display("FAIL err_saturate got %h expected ff", ecnt[1]);
        else passed++;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = '0; offs[d] = '0; rdy[d] = 1'b0;
            m_phase[d] = 0; m_owner[d] = 0; m_last[d] = N - 1; m_field[d] = '0; m_cnt[d] = 0;
        end
        @(posedge clk);
        #1;
        test_reset(0);
        test_reset(1);
        test_single_hold;
        test_back_to_back;
        test_fairness;
        test_overflow;
        test_reset_in_send;
        test_random(0);
        test_random(1);
`ifdef AH_ENC_ERR_COUNT_EN
        test_err_saturate;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
